// File: rtl/reset_request_gen_if.sv
// Purpose : groups the button input and reset-request outputs of reset_request_gen.
// Latency : n/a (wires only).
// Backpr. : none; the outputs are level signals with no handshake.
// Ports   : btn_n_raw (button in, active-low), ext_reset_n (request out, active-low),
//           busy (FSM not idle), req_count (saturating count of button pulses).
interface reset_request_gen_if;
    logic       btn_n_raw;
    logic       ext_reset_n;
    logic       busy;
    logic [7:0] req_count;

    // master drives the button and observes the request (board / bench side)
    modport master (
        output btn_n_raw,
        input  ext_reset_n,
        input  busy,
        input  req_count
    );

    // slave is the generator itself
    modport slave (
        input  btn_n_raw,
        output ext_reset_n,
        output busy,
        output req_count
    );
endinterface

// File: rtl/reset_request_gen.sv
// Purpose : power-on reset interval, then debounced push-button -> one fixed-width
//           active-low reset request pulse per validated press.
// Latency : press accepted 2+DEBOUNCE_CYCLES edges after the raw level is first sampled.
// Backpr. : none; button activity during a pulse or before a stable release is ignored.
// Ports   : clk_sys (system clock), arst (async active-high reset),
//           bus.slave (btn_n_raw in; ext_reset_n, busy, req_count out).
module reset_request_gen #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int PULSE_CYCLES    = 16,
    parameter int POR_CYCLES      = 64
) (
    input  logic             clk_sys,
    input  logic             arst,
    reset_request_gen_if.slave bus
);

    localparam int MAX_AB = (DEBOUNCE_CYCLES > PULSE_CYCLES) ? DEBOUNCE_CYCLES : PULSE_CYCLES;
    localparam int MAX_C  = (MAX_AB > POR_CYCLES) ? MAX_AB : POR_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C) + 1;

    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PUL_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] POR_LAST = CNT_W'(POR_CYCLES - 1);

    localparam logic [2:0] ST_POR          = 3'd0;
    localparam logic [2:0] ST_IDLE         = 3'd1;
    localparam logic [2:0] ST_DEBOUNCE     = 3'd2;
    localparam logic [2:0] ST_ASSERT       = 3'd3;
    localparam logic [2:0] ST_WAIT_RELEASE = 3'd4;

    logic             sync1_q;
    logic             btn_s_q;
    logic [2:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             ext_reset_n_q;
    logic             busy_q;
    logic [7:0]       req_count_q, req_count_d;

    // Two-flop synchronizer; resets to "released" so reset never looks like a press.
    always_ff @(posedge clk_sys or posedge arst) begin
        if (arst) begin
            sync1_q <= 1'b1;
            btn_s_q <= 1'b1;
        end else begin
            sync1_q <= bus.btn_n_raw;
            btn_s_q <= sync1_q;
        end
    end

    // Next-state logic. The single counter is cleared on every state change.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        unique case (state_q)
            ST_POR: begin
                if (cnt_q == POR_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                cnt_d = '0;
                if (!btn_s_q) begin
                    state_d = ST_DEBOUNCE;
                end
            end
            ST_DEBOUNCE: begin
                if (btn_s_q) begin
                    // bounce: drop back without producing a pulse
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_ASSERT;
                    cnt_d   = '0;
                end
            end
            ST_ASSERT: begin
                // button ignored here so the pulse width is fixed
                if (cnt_q == PUL_LAST) begin
                    state_d = ST_WAIT_RELEASE;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_RELEASE: begin
                if (!btn_s_q) begin
                    // any low sample restarts the release count
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_POR;
                cnt_d   = '0;
            end
        endcase
    end

    // Count only on the edge that enters ASSERT; hold at 255.
    always_comb begin
        req_count_d = req_count_q;
        if ((state_d == ST_ASSERT) && (state_q != ST_ASSERT) && (req_count_q != 8'hFF)) begin
            req_count_d = req_count_q + 8'd1;
        end
    end

    // Outputs are registered from the next state so they move on the same edge as the state.
    always_ff @(posedge clk_sys or posedge arst) begin
        if (arst) begin
            state_q       <= ST_POR;
            cnt_q         <= '0;
            ext_reset_n_q <= 1'b0;
            busy_q        <= 1'b1;
            req_count_q   <= 8'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            ext_reset_n_q <= !((state_d == ST_POR) || (state_d == ST_ASSERT));
            busy_q        <= (state_d != ST_IDLE);
            req_count_q   <= req_count_d;
        end
    end

    assign bus.ext_reset_n = ext_reset_n_q;
    assign bus.busy        = busy_q;
    assign bus.req_count   = req_count_q;

endmodule

// File: tb/tb_reset_request_gen.sv
// Purpose : self-checking bench for reset_request_gen (DEBOUNCE=4, PULSE=3, POR=5).
// Latency : n/a.
// Backpr. : n/a; a deadline-based reference model is compared every cycle, plus literal checks.
module tb_reset_request_gen;

    localparam int DB  = 4;
    localparam int PC  = 3;
    localparam int PORC = 5;

    localparam int M_POR  = 0;
    localparam int M_IDLE = 1;
    localparam int M_DEB  = 2;
    localparam int M_ASR  = 3;
    localparam int M_WR   = 4;

    logic clk_sys = 1'b0;
    logic arst    = 1'b1;

    reset_request_gen_if bus_if ();

    reset_request_gen #(
        .DEBOUNCE_CYCLES(DB),
        .PULSE_CYCLES   (PC),
        .POR_CYCLES     (PORC)
    ) dut (
        .clk_sys(clk_sys),
        .arst   (arst),
        .bus    (bus_if)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    // Reference model: absolute edge numbers and deadlines, not per-cycle counters.
    int m_mode  = M_POR;
    int m_edge  = 0;
    int m_dead  = 0;
    int m_cnt   = 0;
    int m_s1    = 1;
    int m_s2    = 1;

    task automatic model_step();
        int bs;
        if (arst) begin
            m_mode = M_POR;
            m_edge = 0;
            m_cnt  = 0;
            m_s1   = 1;
            m_s2   = 1;
        end else begin
            m_edge = m_edge + 1;
            bs     = m_s2;          // synchronized level as seen before this edge
            case (m_mode)
                M_POR:  if (m_edge == PORC) m_mode = M_IDLE;
                M_IDLE: if (bs == 0) begin
                            m_mode = M_DEB;
                            m_dead = m_edge + DB;
                        end
                M_DEB:  if (bs == 1) m_mode = M_IDLE;
                        else if (m_edge == m_dead) begin
                            m_mode = M_ASR;
                            m_dead = m_edge + PC;
                            if (m_cnt < 255) m_cnt = m_cnt + 1;
                        end
                M_ASR:  if (m_edge == m_dead) begin
                            m_mode = M_WR;
                            m_dead = m_edge + DB;
                        end
                M_WR:   if (bs == 0) m_dead = m_edge + DB;
                        else if (m_edge == m_dead) m_mode = M_IDLE;
                default: m_mode = M_POR;
            endcase
            m_s2 = m_s1;
            m_s1 = int'(bus_if.btn_n_raw);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk_sys or posedge arst);
            model_step();
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        @(negedge clk_sys);
        forever begin
            @(negedge clk_sys);
            #1;
            chk("model_ext_reset_n", int'(bus_if.ext_reset_n),
                ((m_mode == M_POR) || (m_mode == M_ASR)) ? 0 : 1);
            chk("model_busy", int'(bus_if.busy), (m_mode != M_IDLE) ? 1 : 0);
            chk("model_req_count", int'(bus_if.req_count), m_cnt);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    int saw_low;

    initial begin
        bus_if.btn_n_raw = 1'b1;
        arst = 1'b1;

        // Power-on
        step(3);
        chk("rst_ext_reset_n", int'(bus_if.ext_reset_n), 0);
        chk("rst_busy", int'(bus_if.busy), 1);
        chk("rst_req_count", int'(bus_if.req_count), 0);
        arst = 1'b0;
        step(4);
        chk("por_edge4_ext_low", int'(bus_if.ext_reset_n), 0);
        step(1);
        chk("por_edge5_ext_high", int'(bus_if.ext_reset_n), 1);
        chk("por_edge5_busy", int'(bus_if.busy), 0);
        chk("por_req_count", int'(bus_if.req_count), 0);

        // Clean press, first sampled at E0
        step(2);
        bus_if.btn_n_raw = 1'b0;
        step(6);
        chk("press_e5_ext_high", int'(bus_if.ext_reset_n), 1);
        step(1);
        chk("press_e6_ext_low", int'(bus_if.ext_reset_n), 0);
        step(1);
        chk("press_e7_ext_low", int'(bus_if.ext_reset_n), 0);
        step(1);
        chk("press_e8_ext_low", int'(bus_if.ext_reset_n), 0);
        step(1);
        chk("press_e9_ext_high", int'(bus_if.ext_reset_n), 1);
        chk("press_req_count", int'(bus_if.req_count), 1);

        // Held button: no second pulse
        saw_low = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (bus_if.ext_reset_n == 1'b0) saw_low = 1;
        end
        chk("held_no_second_pulse", saw_low, 0);
        chk("held_req_count", int'(bus_if.req_count), 1);

        // Release with a 2-cycle low glitch
        bus_if.btn_n_raw = 1'b1;
        step(3);
        bus_if.btn_n_raw = 1'b0;
        step(2);
        bus_if.btn_n_raw = 1'b1;
        step(5);
        chk("release_busy_held", int'(bus_if.busy), 1);
        step(1);
        chk("release_busy_drop", int'(bus_if.busy), 0);

        // Second clean press
        bus_if.btn_n_raw = 1'b0;
        step(10);
        bus_if.btn_n_raw = 1'b1;
        step(10);
        chk("second_press_count", int'(bus_if.req_count), 2);

        // Bounce rejection in IDLE
        saw_low = 0;
        bus_if.btn_n_raw = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step(1);
            if (bus_if.ext_reset_n == 1'b0) saw_low = 1;
            if (i == 2) bus_if.btn_n_raw = 1'b1;
            if (i == 3) bus_if.btn_n_raw = 1'b0;
            if (i == 5) bus_if.btn_n_raw = 1'b1;
        end
        chk("bounce_no_pulse", saw_low, 0);
        chk("bounce_req_count", int'(bus_if.req_count), 2);

        // Reset during the 2nd low cycle of a pulse
        bus_if.btn_n_raw = 1'b0;
        step(8);
        chk("midpulse_pre_ext_low", int'(bus_if.ext_reset_n), 0);
        #2;
        arst = 1'b1;
        #1;
        chk("midpulse_arst_ext", int'(bus_if.ext_reset_n), 0);
        chk("midpulse_arst_count", int'(bus_if.req_count), 0);
        chk("midpulse_arst_busy", int'(bus_if.busy), 1);
        step(1);
        arst = 1'b0;
        bus_if.btn_n_raw = 1'b1;
        step(4);
        chk("midpulse_por4_ext", int'(bus_if.ext_reset_n), 0);
        step(1);
        chk("midpulse_por5_ext", int'(bus_if.ext_reset_n), 1);

        // Randomized button activity with occasional async resets
        for (int i = 0; i < 80; i++) begin
            bus_if.btn_n_raw = 1'($urandom_range(0, 1));
            step($urandom_range(1, 9));
            if ($urandom_range(0, 24) == 0) begin
                #3;
                arst = 1'b1;
                #4;
                arst = 1'b0;
            end
        end

        // Saturation from a known zero count
        step(1);
        arst = 1'b1;
        step(2);
        arst = 1'b0;
        bus_if.btn_n_raw = 1'b1;
        step(8);
        chk("sat_start_count", int'(bus_if.req_count), 0);
        for (int i = 0; i < 260; i++) begin
            bus_if.btn_n_raw = 1'b0;
            step(8 + $urandom_range(0, 3));
            bus_if.btn_n_raw = 1'b1;
            step(8 + $urandom_range(0, 3));
            if (i == 253) chk("sat_254", int'(bus_if.req_count), 254);
            if (i == 254) chk("sat_255", int'(bus_if.req_count), 255);
        end
        chk("sat_hold_255", int'(bus_if.req_count), 255);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
